// File: rtl/display_scan_ctrl.sv
// Multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Each digit slot has anode dead-time, then the lit phase; digits come from a per-frame snapshot.
module display_scan_ctrl #(
   parameter int NDIG      = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500,
   localparam int IDX_W    = $clog2(NDIG),
   localparam int CNT_W    = $clog2(SCAN_DIV)
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              en,
   input  logic [4*NDIG-1:0] bcd_in,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              lz_en,
   output logic [NDIG-1:0]   an,
   output logic [3:0]        bcd_out,
   output logic              dp_out,
   output logic              blank_out,
   output logic [IDX_W-1:0]  digit_idx,
   output logic              frame_tick
);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx_n;
   logic [4*NDIG-1:0] snap_bcd, snap_bcd_n;
   logic [NDIG-1:0]   snap_dp, snap_dp_n;
   logic              snap_lz, snap_lz_n;
   logic [NDIG-1:0]   an_n;
   logic [3:0]        bcd_n;
   logic [3:0]        dig;
   logic              dp_n, blank_n, tick_n;

   // True when digit idx and every more-significant digit are zero.
   function automatic logic upper_zero(input logic [4*NDIG-1:0] bcd,
                                       input logic [IDX_W-1:0]  idx);
      logic z;
      z = 1'b1;
      for (int i = 0; i < NDIG; i++)
         if (i >= int'(idx) && bcd[4*i +: 4] != 4'd0)
            z = 1'b0;
      return z;
   endfunction

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = digit_idx;
      snap_bcd_n = snap_bcd;
      snap_dp_n  = snap_dp;
      snap_lz_n  = snap_lz;
      tick_n     = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n    = BLANK;
               cnt_n      = '0;
               idx_n      = '0;
               snap_bcd_n = bcd_in;
               snap_dp_n  = dp_in;
               snap_lz_n  = lz_en;
            end
            BLANK: begin
               cnt_n = cnt + CNT_W'(1);
               if (cnt == BLANK_LAST)
                  state_n = SHOW;
            end
            SHOW: begin
               if (cnt == SLOT_LAST) begin
                  cnt_n   = '0;
                  state_n = BLANK;
                  if (digit_idx == IDX_LAST) begin
                     // Frame boundary: the only point where new inputs become visible.
                     idx_n      = '0;
                     tick_n     = 1'b1;
                     snap_bcd_n = bcd_in;
                     snap_dp_n  = dp_in;
                     snap_lz_n  = lz_en;
                  end else begin
                     idx_n = digit_idx + IDX_W'(1);
                  end
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Outputs are derived from the next-state values so they register in step with the state.
   always_comb begin
      an_n    = '1;
      bcd_n   = 4'd0;
      dp_n    = 1'b0;
      blank_n = 1'b1;
      dig     = snap_bcd_n[4*idx_n +: 4];
      if (state_n == SHOW) begin
         an_n[idx_n] = 1'b0;
         bcd_n       = dig;
         blank_n     = (dig > 4'd9) ||
                       (snap_lz_n && idx_n != '0 && upper_zero(snap_bcd_n, idx_n));
         dp_n        = snap_dp_n[idx_n] & ~blank_n;
      end
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         digit_idx  <= '0;
         snap_bcd   <= '0;
         snap_dp    <= '0;
         snap_lz    <= 1'b0;
         an         <= '1;
         bcd_out    <= 4'd0;
         dp_out     <= 1'b0;
         blank_out  <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         digit_idx  <= idx_n;
         snap_bcd   <= snap_bcd_n;
         snap_dp    <= snap_dp_n;
         snap_lz    <= snap_lz_n;
         an         <= an_n;
         bcd_out    <= bcd_n;
         dp_out     <= dp_n;
         blank_out  <= blank_n;
         frame_tick <= tick_n;
      end
   end

endmodule
